// File: rtl/keypad_time_encoder.sv
// Keypad front end: 2-flop sync, press/release debounce FSM, one-hot to BCD
// encode, and a right-to-left shifting M:SS entry register.
module keypad_time_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] keypad,
    input  logic       enable_entry,
    input  logic       clear_entry,
    output logic [3:0] minutes,
    output logic [3:0] second_tens,
    output logic [3:0] second_units,
    output logic       key_valid,
    output logic       key_error,
    output logic       entry_nonzero
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [9:0]       sync1_q, sampled_q;
    logic [9:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       minutes_q, minutes_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;
    logic             key_valid_q, key_valid_d;
    logic             key_error_q, key_error_d;
    logic [3:0]       digit;
    logic             cand_onehot;
    logic             accept;

    always_comb begin
        digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (cand_q[k]) digit = 4'(k);
        end
    end

    assign cand_onehot = (cand_q != 10'd0) && ((cand_q & (cand_q - 10'd1)) == 10'd0);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        minutes_d   = minutes_q;
        tens_d      = tens_q;
        units_d     = units_q;
        key_valid_d = 1'b0;
        key_error_d = 1'b0;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                if (sampled_q != 10'd0) begin
                    cand_d  = sampled_q;
                    cnt_d   = CNT_ONE;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sampled_q != cand_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = HELD;
                    // A units digit above 5 would become an illegal tens digit.
                    if (!cand_onehot)       key_error_d = 1'b1;
                    else if (!enable_entry) accept      = 1'b0;
                    else if (units_q > 4'd5) key_error_d = 1'b1;
                    else                    accept      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (sampled_q == 10'd0) begin
                    cnt_d   = CNT_ONE;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (sampled_q != 10'd0) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (clear_entry) begin
            minutes_d = 4'd0;
            tens_d    = 4'd0;
            units_d   = 4'd0;
        end else if (accept) begin
            minutes_d   = tens_q;
            tens_d      = units_q;
            units_d     = digit;
            key_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= '0;
            sampled_q   <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            minutes_q   <= '0;
            tens_q      <= '0;
            units_q     <= '0;
            key_valid_q <= 1'b0;
            key_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= keypad;
            sampled_q   <= sync1_q;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            minutes_q   <= minutes_d;
            tens_q      <= tens_d;
            units_q     <= units_d;
            key_valid_q <= key_valid_d;
            key_error_q <= key_error_d;
        end
    end

    assign minutes       = minutes_q;
    assign second_tens   = tens_q;
    assign second_units  = units_q;
    assign key_valid     = key_valid_q;
    assign key_error     = key_error_q;
    assign entry_nonzero = |{minutes_q, tens_q, units_q};

endmodule
